// File: rtl/io_responder.sv
// rtl/io_responder.sv - memory-mapped I/O responder: GPIO, prescaled timer with compare/irq, TX byte FIFO
// Decodes a 16-byte window at BASE_ADDR; every clock edge is a bus access.
module io_responder #(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int          TX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rw,
  input  logic [15:0] addr,
  input  logic [7:0]  data,
  output logic [7:0]  q,
  output logic        hit,
  input  logic [7:0]  gpio_in,
  output logic [7:0]  gpio_out,
  output logic        irq,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam logic [AW:0] FULL_CNT = TX_DEPTH[AW:0];

  logic       in_win;
  logic       wr;
  logic [3:0] off;
  logic       wr_gpio, wr_ctrl, wr_presc, wr_cnt, wr_cmp, wr_status, wr_tx;

  assign in_win    = (addr[15:4] == BASE_ADDR[15:4]);
  assign wr        = rw & in_win;
  assign off       = addr[3:0];
  assign wr_gpio   = wr & (off == 4'd0);
  assign wr_ctrl   = wr & (off == 4'd2);
  assign wr_presc  = wr & (off == 4'd3);
  assign wr_cnt    = wr & (off == 4'd4);
  assign wr_cmp    = wr & (off == 4'd5);
  assign wr_status = wr & (off == 4'd6);
  assign wr_tx     = wr & (off == 4'd7);

  logic [7:0] sync1, sync2;
  logic [3:0] ctrl;
  logic [7:0] presc, pcnt, cnt, cmp;
  logic       match, tx_ovf;

  logic [7:0]    mem [TX_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          full, empty, pop, push, push_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign pop     = !empty & tx_ready;
  assign push    = wr_tx;
  // A full FIFO still accepts a byte when the head leaves in the same cycle
  assign push_ok = push & (!full | pop);

  assign tx_valid = !empty;
  assign tx_data  = mem[rd_ptr];
  assign irq      = (match & ctrl[2]) | (tx_ovf & ctrl[3]);

  logic tick, cnt_eq;
  assign tick   = ctrl[0] & (pcnt == presc);
  assign cnt_eq = (cnt == cmp);

  logic [7:0] rdata;
  always_comb begin
    rdata = 8'h00;
    case (off)
      4'd0: rdata = gpio_out;
      4'd1: rdata = sync2;
      4'd2: rdata = {4'b0000, ctrl};
      4'd3: rdata = presc;
      4'd4: rdata = cnt;
      4'd5: rdata = cmp;
      4'd6: rdata = {4'b0000, tx_ovf, empty, full, match};
      default: rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= 8'h00;
      hit   <= 1'b0;
      sync1 <= 8'h00;
      sync2 <= 8'h00;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      if (rw) begin
        hit <= 1'b0;
      end else begin
        hit <= in_win;
        q   <= in_win ? rdata : 8'h00;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_out <= 8'h00;
      ctrl     <= 4'h0;
      presc    <= 8'h00;
      cmp      <= 8'h00;
    end else begin
      if (wr_gpio)  gpio_out <= data;
      if (wr_ctrl)  ctrl     <= data[3:0];
      if (wr_presc) presc    <= data;
      if (wr_cmp)   cmp      <= data;
    end
  end

  // A CNT write swallows any tick in the same cycle, including its match
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt  <= 8'h00;
      cnt   <= 8'h00;
      match <= 1'b0;
    end else begin
      if (wr_presc || !ctrl[0] || tick) pcnt <= 8'h00;
      else                              pcnt <= pcnt + 8'd1;

      if (wr_cnt)                     cnt <= data;
      else if (tick && cnt_eq && ctrl[1]) cnt <= 8'h00;
      else if (tick)                  cnt <= cnt + 8'd1;

      if (tick && !wr_cnt && cnt_eq)      match <= 1'b1;
      else if (wr_status && data[0])      match <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      tx_ovf <= 1'b0;
      for (int i = 0; i < TX_DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;

      if (push && !push_ok)          tx_ovf <= 1'b1;
      else if (wr_status && data[3]) tx_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_responder.sv
// tb/tb_io_responder.sv - self-checking bench for io_responder
// A queue/array reference model predicts every output; directed steps pin literal values.
module tb_io_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rw = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  data = 8'h00;
  logic [7:0]  q;
  logic        hit;
  logic [7:0]  gpio_in = 8'h00;
  logic [7:0]  gpio_out;
  logic        irq;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  io_responder #(.BASE_ADDR(16'hFF00), .TX_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rw(rw), .addr(addr), .data(data), .q(q), .hit(hit),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain integers, a byte queue for the FIFO, a gpio history queue
  logic [7:0] m_gpio_out = 0, m_presc = 0, m_cmp = 0, m_q = 0;
  logic [3:0] m_ctrl = 0;
  int         m_cnt = 0, m_pcnt = 0;
  bit         m_hit = 0, m_match = 0, m_ovf = 0;
  logic [7:0] m_fifo[$];
  logic [7:0] g_hist[$];

  bit         t_in, t_wr, t_tick;
  logic [3:0] t_off;
  logic [7:0] t_rd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_gpio_out = 0; m_presc = 0; m_cmp = 0; m_q = 0; m_ctrl = 0;
      m_cnt = 0; m_pcnt = 0; m_hit = 0; m_match = 0; m_ovf = 0;
      m_fifo.delete();
      g_hist.delete();
      g_hist.push_back(8'h00);
      g_hist.push_back(8'h00);
    end else begin
      t_in  = (addr[15:4] == 12'hFF0);
      t_off = addr[3:0];
      t_wr  = rw && t_in;
      case (t_off)
        4'd0: t_rd = m_gpio_out;
        4'd1: t_rd = g_hist[$-1];
        4'd2: t_rd = {4'b0000, m_ctrl};
        4'd3: t_rd = m_presc;
        4'd4: t_rd = m_cnt[7:0];
        4'd5: t_rd = m_cmp;
        4'd6: t_rd = {4'b0000, m_ovf, m_fifo.size() == 0, m_fifo.size() == 4, m_match};
        default: t_rd = 8'h00;
      endcase
      if (rw) m_hit = 0;
      else begin
        m_hit = t_in;
        m_q   = t_in ? t_rd : 8'h00;
      end
      g_hist.push_back(gpio_in);
      if (g_hist.size() > 4) void'(g_hist.pop_front());

      t_tick = m_ctrl[0] && (m_pcnt == int'(m_presc));
      if (t_wr && t_off == 4'd6 && data[0]) m_match = 0;
      if (t_tick && !(t_wr && t_off == 4'd4) && m_cnt == int'(m_cmp)) m_match = 1;
      if (t_wr && t_off == 4'd4) m_cnt = int'(data);
      else if (t_tick) m_cnt = (m_cnt == int'(m_cmp) && m_ctrl[1]) ? 0 : (m_cnt + 1) % 256;
      if ((t_wr && t_off == 4'd3) || !m_ctrl[0] || t_tick) m_pcnt = 0;
      else m_pcnt = m_pcnt + 1;

      if (t_wr && t_off == 4'd6 && data[3]) m_ovf = 0;
      if (m_fifo.size() > 0 && tx_ready) void'(m_fifo.pop_front());
      if (t_wr && t_off == 4'd7) begin
        if (m_fifo.size() < 4) m_fifo.push_back(data);
        else m_ovf = 1;
      end

      if (t_wr && t_off == 4'd0) m_gpio_out = data;
      if (t_wr && t_off == 4'd2) m_ctrl = data[3:0];
      if (t_wr && t_off == 4'd3) m_presc = data;
      if (t_wr && t_off == 4'd5) m_cmp = data;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("q", q, m_q);
      chk("hit", {7'd0, hit}, {7'd0, m_hit});
      chk("gpio_out", gpio_out, m_gpio_out);
      chk("irq", {7'd0, irq}, {7'd0, (m_match & m_ctrl[2]) | (m_ovf & m_ctrl[3])});
      chk("tx_valid", {7'd0, tx_valid}, {7'd0, m_fifo.size() > 0});
      if (m_fifo.size() > 0) chk("tx_data", tx_data, m_fifo[0]);
    end
  end

  task automatic bus(input logic w, input logic [15:0] a, input logic [7:0] d);
    rw = w; addr = a; data = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) bus(1'b0, 16'h0000, 8'h00);
  endtask

  task automatic drain(input logic [7:0] e0, input logic [7:0] e1,
                       input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] got[$];
    logic [7:0] exp[4];
    int k = 0;
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    tx_ready = 1'b1;
    while (got.size() < 4 && k < 12) begin
      if (tx_valid) got.push_back(tx_data);
      idle(1);
      k++;
    end
    chk("drain_count", 8'(got.size()), 8'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("drain_byte", got[i], exp[i]);
    chk("drain_empty", {7'd0, tx_valid}, 8'd0);
    tx_ready = 1'b0;
  endtask

  initial begin
    int k;
    repeat (2) @(negedge clk);
    chk("rst_q", q, 8'h00);
    chk("rst_hit", {7'd0, hit}, 8'd0);
    chk("rst_gpio_out", gpio_out, 8'h00);
    chk("rst_irq", {7'd0, irq}, 8'd0);
    chk("rst_tx_valid", {7'd0, tx_valid}, 8'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    bus(1'b0, 16'hFF06, 8'h00);
    chk("status_reset", q, 8'h04);
    chk("status_hit", {7'd0, hit}, 8'd1);
    bus(1'b0, 16'h1234, 8'h00);
    chk("miss_q", q, 8'h00);
    chk("miss_hit", {7'd0, hit}, 8'd0);

    bus(1'b1, 16'hFF00, 8'hA5);
    chk("gpio_out_wr", gpio_out, 8'hA5);
    bus(1'b0, 16'hFF00, 8'h00);
    chk("gpio_out_rd", q, 8'hA5);
    gpio_in = 8'h3C;
    idle(3);
    bus(1'b0, 16'hFF01, 8'h00);
    chk("gpio_in_rd", q, 8'h3C);

    bus(1'b1, 16'hFF03, 8'd2);
    bus(1'b1, 16'hFF05, 8'd5);
    bus(1'b1, 16'hFF02, 8'h07);
    k = 0;
    while (!irq && k < 40) begin idle(1); k++; end
    chk("match_cycles", 8'(k), 8'd18);
    bus(1'b0, 16'hFF04, 8'h00);
    chk("cnt_cleared", q, 8'h00);
    bus(1'b1, 16'hFF06, 8'h01);
    chk("irq_w1c", {7'd0, irq}, 8'd0);

    bus(1'b1, 16'hFF02, 8'h00);
    bus(1'b1, 16'hFF03, 8'h00);
    bus(1'b1, 16'hFF02, 8'h01);
    bus(1'b1, 16'hFF04, 8'h80);
    bus(1'b0, 16'hFF04, 8'h00);
    chk("cnt_wr_beats_tick", q, 8'h80);
    bus(1'b1, 16'hFF02, 8'h08);

    tx_ready = 1'b0;
    bus(1'b1, 16'hFF07, 8'h11);
    bus(1'b1, 16'hFF07, 8'h22);
    bus(1'b1, 16'hFF07, 8'h33);
    bus(1'b1, 16'hFF07, 8'h44);
    bus(1'b0, 16'hFF06, 8'h00);
    chk("status_full", q, 8'h02);
    bus(1'b1, 16'hFF07, 8'h55);
    bus(1'b0, 16'hFF06, 8'h00);
    chk("status_ovf", q, 8'h0A);
    chk("irq_ovf", {7'd0, irq}, 8'd1);
    drain(8'h11, 8'h22, 8'h33, 8'h44);

    bus(1'b1, 16'hFF06, 8'h08);
    chk("ovf_w1c_irq", {7'd0, irq}, 8'd0);
    bus(1'b1, 16'hFF07, 8'h11);
    bus(1'b1, 16'hFF07, 8'h22);
    bus(1'b1, 16'hFF07, 8'h33);
    bus(1'b1, 16'hFF07, 8'h44);
    tx_ready = 1'b1;
    bus(1'b1, 16'hFF07, 8'h66);
    tx_ready = 1'b0;
    bus(1'b0, 16'hFF06, 8'h00);
    chk("full_pop_push", q, 8'h02);
    drain(8'h22, 8'h33, 8'h44, 8'h66);

    bus(1'b1, 16'hFF02, 8'h01);
    bus(1'b1, 16'hFF07, 8'hAA);
    bus(1'b1, 16'hFF07, 8'hBB);
    idle(3);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tx_valid", {7'd0, tx_valid}, 8'd0);
    chk("mid_rst_gpio_out", gpio_out, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    bus(1'b0, 16'hFF04, 8'h00);
    chk("post_rst_cnt", q, 8'h00);
    bus(1'b0, 16'hFF02, 8'h00);
    chk("post_rst_ctrl", q, 8'h00);

    for (int i = 0; i < 3000; i++) begin
      logic [15:0] a;
      logic [7:0]  d;
      if ($urandom_range(0, 9) == 0) gpio_in = 8'($urandom);
      tx_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) < 17) a = {12'hFF0, 4'($urandom_range(0, 15))};
      else a = 16'($urandom);
      d = 8'($urandom);
      if (a[3:0] == 4'd3) d = d & 8'h03;
      if (a[3:0] == 4'd5) d = d & 8'h0F;
      bus($urandom_range(0, 9) < 4, a, d);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
